// File: rtl/ptp_a_rx.sv
// ptp_a_rx: host-to-core deserialiser; assembles strobed 8-bit or 1-bit units MSB-first into a word
// and delivers it over a valid/ready handshake with a sticky overrun flag.
module ptp_a_rx #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  control_i,
  input  logic                  serialise_i,
  input  logic [7:0]            value_i,
  input  logic                  ready_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  valid_o,
  output logic                  overrun_o,
  output logic [5:0]            count_o
);
  typedef enum logic {EMPTY, FULL} state_t;
  logic                  ctl_s1_q, ctl_s2_q, ctl_s3_q;
  logic [7:0]            val_s1_q, val_s2_q;
  logic                  ser_q;
  logic [WORD_WIDTH-1:0] sh_q, sh_d, word_q, word_d;
  logic [5:0]            cnt_q, cnt_d, last;
  state_t                st_q, st_d;
  logic                  ovr_q, ovr_d;
  logic                  strobe, mode_chg, take, done;
  // A strobe arriving in the same cycle as a mode change is dropped along with the partial word.
  always_comb begin
    mode_chg = serialise_i != ser_q;
    strobe   = ctl_s2_q & ~ctl_s3_q;
    take     = strobe & ~mode_chg;
    last     = serialise_i ? 6'(WORD_WIDTH - 1) : 6'(WORD_WIDTH / 8 - 1);
    done     = take && (cnt_q == last);
    sh_d     = mode_chg ? '0 : !take ? sh_q :
               serialise_i ? {sh_q[WORD_WIDTH-2:0], val_s2_q[0]} : {sh_q[WORD_WIDTH-9:0], val_s2_q};
    cnt_d    = mode_chg ? '0 : !take ? cnt_q : done ? '0 : cnt_q + 6'd1;
    st_d     = st_q;
    word_d   = word_q;
    ovr_d    = ovr_q;
    if (done && (st_q == EMPTY || ready_i)) begin
      st_d   = FULL;
      word_d = sh_d;
    end else if (done) begin
      ovr_d  = 1'b1;
    end else if (st_q == FULL && ready_i) begin
      st_d   = EMPTY;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctl_s1_q <= 1'b0;
      ctl_s2_q <= 1'b0;
      ctl_s3_q <= 1'b0;
      val_s1_q <= '0;
      val_s2_q <= '0;
      ser_q    <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      st_q     <= EMPTY;
      ovr_q    <= 1'b0;
    end else begin
      ctl_s1_q <= control_i;
      ctl_s2_q <= ctl_s1_q;
      ctl_s3_q <= ctl_s2_q;
      val_s1_q <= value_i;
      val_s2_q <= val_s1_q;
      ser_q    <= serialise_i;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      st_q     <= st_d;
      ovr_q    <= ovr_d;
    end
  end
  assign word_o    = word_q;
  assign valid_o   = st_q == FULL;
  assign overrun_o = ovr_q;
  assign count_o   = cnt_q;
endmodule

// File: tb/tb_ptp_a_rx.sv
// tb_ptp_a_rx: directed scenario tests for ptp_a_rx with hand-computed expectations.
module tb_ptp_a_rx;
  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        control_i = 1'b0;
  logic        serialise_i = 1'b0;
  logic [7:0]  value_i = 8'h00;
  logic        ready_i = 1'b0;
  logic [31:0] word_o;
  logic        valid_o, overrun_o;
  logic [5:0]  count_o;
  int checks = 0;
  int errors = 0;

  ptp_a_rx #(.WORD_WIDTH(32)) dut (
    .clk_i(clk), .reset_i(reset_i), .control_i(control_i), .serialise_i(serialise_i),
    .value_i(value_i), .ready_i(ready_i), .word_o(word_o), .valid_o(valid_o),
    .overrun_o(overrun_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(negedge clk) reset_i = 1'b1;
    @(negedge clk) reset_i = 1'b0;
  endtask

  // Raise the strobe and stop at the negedge just before the capturing (3rd) posedge.
  task automatic pre(input logic [7:0] v);
    @(negedge clk) value_i = v;
    @(negedge clk) control_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic post();
    repeat (2) @(negedge clk);
    control_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v);
    pre(v);
    post();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[31-8*i -: 8]);
  endtask

  task automatic test_reset();
    control_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    checks++; if (word_o !== 32'h0) begin errors++; $display("FAIL reset_word got %h exp %h", word_o, 32'h0); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun_o); end
    checks++; if (count_o !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    repeat (4) @(negedge clk);
    checks++; if (count_o !== 6'd1) begin errors++; $display("FAIL reset_held_strobe got %0d exp 1", count_o); end
    control_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_parallel();
    pulse_reset();
    serialise_i = 1'b0;
    send(8'hDE);
    checks++; if (count_o !== 6'd1) begin errors++; $display("FAIL par_count1 got %0d exp 1", count_o); end
    send(8'hAD);
    checks++; if (count_o !== 6'd2) begin errors++; $display("FAIL par_count2 got %0d exp 2", count_o); end
    send(8'hBE);
    checks++; if (count_o !== 6'd3) begin errors++; $display("FAIL par_count3 got %0d exp 3", count_o); end
    pre(8'hEF);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL par_early_valid got %b exp 0", valid_o); end
    @(negedge clk);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL par_valid got %b exp 1", valid_o); end
    checks++; if (word_o !== 32'hDEADBEEF) begin errors++; $display("FAIL par_word got %h exp %h", word_o, 32'hDEADBEEF); end
    checks++; if (count_o !== 6'd0) begin errors++; $display("FAIL par_count0 got %0d exp 0", count_o); end
    post();
  endtask

  task automatic test_serial();
    logic [31:0] d;
    d = 32'hCAFEB0BA;
    pulse_reset();
    @(negedge clk) serialise_i = 1'b1;
    for (int i = 0; i < 31; i++) send({7'h7F, d[31-i]});
    checks++; if (count_o !== 6'd31) begin errors++; $display("FAIL ser_count31 got %0d exp 31", count_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ser_early_valid got %b exp 0", valid_o); end
    send({7'h7F, d[0]});
    checks++; if (word_o !== 32'hCAFEB0BA) begin errors++; $display("FAIL ser_word got %h exp %h", word_o, 32'hCAFEB0BA); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ser_valid got %b exp 1", valid_o); end
    checks++; if (count_o !== 6'd0) begin errors++; $display("FAIL ser_count0 got %0d exp 0", count_o); end
    @(negedge clk) serialise_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overrun();
    pulse_reset();
    ready_i = 1'b0;
    send_word(32'h11111111);
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_first got %b exp 0", overrun_o); end
    send_word(32'h22222222);
    checks++; if (word_o !== 32'h11111111) begin errors++; $display("FAIL ovr_word got %h exp %h", word_o, 32'h11111111); end
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun_o); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", valid_o); end
    @(negedge clk) ready_i = 1'b1;
    @(negedge clk) ready_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ovr_accept_valid got %b exp 0", valid_o); end
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun_o); end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    ready_i = 1'b0;
    send_word(32'hAAAA5555);
    checks++; if (word_o !== 32'hAAAA5555) begin errors++; $display("FAIL b2b_first got %h exp %h", word_o, 32'hAAAA5555); end
    send(8'h01);
    send(8'h23);
    send(8'h45);
    pre(8'h67);
    ready_i = 1'b1;
    @(negedge clk) ready_i = 1'b0;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", valid_o); end
    checks++; if (word_o !== 32'h01234567) begin errors++; $display("FAIL b2b_word got %h exp %h", word_o, 32'h01234567); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun_o); end
    post();
  endtask

  task automatic test_mode_change();
    pulse_reset();
    serialise_i = 1'b0;
    send(8'h12);
    send(8'h34);
    checks++; if (count_o !== 6'd2) begin errors++; $display("FAIL mode_pre_count got %0d exp 2", count_o); end
    @(negedge clk) serialise_i = 1'b1;
    @(negedge clk);
    checks++; if (count_o !== 6'd0) begin errors++; $display("FAIL mode_toggle1 got %0d exp 0", count_o); end
    serialise_i = 1'b0;
    @(negedge clk);
    checks++; if (count_o !== 6'd0) begin errors++; $display("FAIL mode_toggle2 got %0d exp 0", count_o); end
    send_word(32'h55667788);
    checks++; if (word_o !== 32'h55667788) begin errors++; $display("FAIL mode_word got %h exp %h", word_o, 32'h55667788); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL mode_valid got %b exp 1", valid_o); end
  endtask

  task automatic test_reset_mid_word();
    serialise_i = 1'b0;
    send(8'hFF);
    send(8'hFF);
    checks++; if (count_o !== 6'd2) begin errors++; $display("FAIL rmid_pre_count got %0d exp 2", count_o); end
    pulse_reset();
    checks++; if (word_o !== 32'h0) begin errors++; $display("FAIL rmid_word0 got %h exp %h", word_o, 32'h0); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid0 got %b exp 0", valid_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rmid_overrun0 got %b exp 0", overrun_o); end
    checks++; if (count_o !== 6'd0) begin errors++; $display("FAIL rmid_count0 got %0d exp 0", count_o); end
    send_word(32'h01020304);
    checks++; if (word_o !== 32'h01020304) begin errors++; $display("FAIL rmid_word got %h exp %h", word_o, 32'h01020304); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rmid_valid got %b exp 1", valid_o); end
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_serial();
    test_overrun();
    test_back_to_back();
    test_mode_change();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
